// File: rtl/led_stretch_pkg.sv
// Shared types and helpers for the LED pulse stretcher: one-hot channel state
// and the timer width derived from the longer of the two durations.
package led_stretch_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_ON   = 3'b010,
        S_GAP  = 3'b100
    } state_t;

    function automatic int timer_width(input int on_cycles, input int gap_cycles);
        int longest;
        longest = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/led_stretch_channel.sv
// One LED stretch channel: IDLE/ON/GAP FSM, saturating timer and, when
// LED_STRETCH_QUEUE_EN is defined, a saturating pending-event counter.
module led_stretch_channel
    import led_stretch_pkg::*;
#(
    parameter int ON_CYCLES  = 10_000_000,
    parameter int GAP_CYCLES = 5_000_000,
    parameter int QDEPTH_W   = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pulse,
    output logic o_led,
    output logic o_busy,
    output logic o_overflow
);

    localparam int            TW       = timer_width(ON_CYCLES, GAP_CYCLES);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    state_t        r_state, w_state_next;
    logic [TW-1:0] r_timer, w_timer_next;
    logic          r_overflow, w_overflow_next;
    logic          w_enq, w_deq, w_has_pending;

    always_comb begin
        w_state_next = r_state;
        w_timer_next = (r_state != S_IDLE && r_timer != '1) ? r_timer + 1'b1 : r_timer;
        w_enq        = 1'b0;
        w_deq        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_pulse || w_has_pending) begin
                    w_state_next = S_ON;
                    w_timer_next = '0;
                    w_deq        = !i_pulse;
                end
            end
            S_ON: begin
                w_enq = i_pulse;
                if (r_timer == ON_LAST) begin
                    w_state_next = S_GAP;
                    w_timer_next = '0;
                end
            end
            S_GAP: begin
                if (r_timer == GAP_LAST) begin
                    w_timer_next = '0;
                    if (w_has_pending) begin
                        // Replay one queued event; a new arrival this cycle takes its slot.
                        w_state_next = S_ON;
                        w_deq        = 1'b1;
                        w_enq        = i_pulse;
                    end else if (i_pulse) begin
                        w_state_next = S_ON;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_enq = i_pulse;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_timer_next = '0;
            end
        endcase
    end

`ifdef LED_STRETCH_QUEUE_EN
    localparam logic [QDEPTH_W-1:0] Q_MAX = '1;

    logic [QDEPTH_W-1:0] r_pending;
    logic                w_q_full;

    assign w_q_full        = (r_pending == Q_MAX);
    assign w_has_pending   = (r_pending != '0);
    assign w_overflow_next = w_enq && !w_deq && w_q_full;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= '0;
        end else if (w_enq && !w_deq && !w_q_full) begin
            r_pending <= r_pending + 1'b1;
        end else if (w_deq && !w_enq) begin
            r_pending <= r_pending - 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_unused        = w_deq ^ 1'(QDEPTH_W);
    assign w_has_pending   = 1'b0;
    assign w_overflow_next = w_enq;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_overflow <= w_overflow_next;
        end
    end

    // The ON bit of the one-hot state register drives the LED directly.
    assign o_led      = r_state[1];
    assign o_busy     = (r_state != S_IDLE) || w_has_pending;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/led_pulse_stretch.sv
// Multi-channel LED pulse stretcher with optional output inversion.
// Event queuing is enabled by defining LED_STRETCH_QUEUE_EN.
module led_pulse_stretch #(
    parameter int CH             = 4,
    parameter int ON_CYCLES      = 10_000_000,
    parameter int GAP_CYCLES     = 5_000_000,
    parameter int QDEPTH_W       = 4,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] pulse_in,
    output logic [CH-1:0] led_out,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] overflow
);

    logic [CH-1:0] w_led;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            led_stretch_channel #(
                .ON_CYCLES (ON_CYCLES),
                .GAP_CYCLES(GAP_CYCLES),
                .QDEPTH_W  (QDEPTH_W)
            ) u_channel (
                .i_clk     (clk),
                .i_rst     (rst),
                .i_pulse   (pulse_in[gi]),
                .o_led     (w_led[gi]),
                .o_busy    (busy[gi]),
                .o_overflow(overflow[gi])
            );
        end
    endgenerate

    assign led_out = LED_ACTIVE_LOW ? ~w_led : w_led;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Directed bench for led_pulse_stretch: per-cycle vector tables built from
// hand-computed window masks, plus a hand-written asynchronous reset sequence.
module tb_led_pulse_stretch;

    localparam int CH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] pulse_in = '0;
    logic [CH-1:0] led_out, busy, overflow;
    logic [CH-1:0] led_al, busy_al, ovf_al;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] pulse;
        logic [1:0] led;
        logic [1:0] busy;
        logic [1:0] ovf;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    led_pulse_stretch #(
        .CH(CH), .ON_CYCLES(4), .GAP_CYCLES(2), .QDEPTH_W(2), .LED_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in),
        .led_out(led_out), .busy(busy), .overflow(overflow)
    );

    led_pulse_stretch #(
        .CH(CH), .ON_CYCLES(4), .GAP_CYCLES(2), .QDEPTH_W(2), .LED_ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst(rst), .pulse_in(pulse_in),
        .led_out(led_al), .busy(busy_al), .overflow(ovf_al)
    );

    function automatic logic [63:0] rm(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Bit e of a pulse mask = pulse sampled at edge e; bit c of an expectation
    // mask = level during cycle c (the cycle after edge c-1).
    task automatic build(input int ncyc, input logic [63:0] p0, input logic [63:0] p1,
                         input logic [63:0] l0, input logic [63:0] l1,
                         input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] o0);
        vecs.delete();
        for (int e = 0; e < ncyc; e++) begin
            vec_t v;
            v.pulse = {p1[e], p0[e]};
            v.led   = {l1[e+1], l0[e+1]};
            v.busy  = {b1[e+1], b0[e+1]};
            v.ovf   = {1'b0, o0[e+1]};
            vecs.push_back(v);
        end
    endtask

    task automatic run(input string name);
        foreach (vecs[i]) begin
            @(negedge clk);
            pulse_in = vecs[i].pulse;
            @(posedge clk);
            #1;
            n_tests++;
            if (led_out !== vecs[i].led || busy !== vecs[i].busy || overflow !== vecs[i].ovf ||
                led_al !== ~vecs[i].led || busy_al !== vecs[i].busy || ovf_al !== vecs[i].ovf) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got led=%b busy=%b ovf=%b led_al=%b busy_al=%b ovf_al=%b required led=%b busy=%b ovf=%b led_al=%b",
                         name, i + 1, led_out, busy, overflow, led_al, busy_al, ovf_al,
                         vecs[i].led, vecs[i].busy, vecs[i].ovf, ~vecs[i].led);
            end else begin
                $display("[TB] %s cyc=%0d pulse=%b led=%b busy=%b ovf=%b",
                         name, i + 1, vecs[i].pulse, led_out, busy, overflow);
            end
        end
        @(negedge clk);
        pulse_in = '0;
    endtask

    // Packed as {led_out, busy, overflow, led_al, busy_al, ovf_al}.
    task automatic chk(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = {led_out, busy, overflow, led_al, busy_al, ovf_al};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b required=%b", name, got, exp);
        end else begin
            $display("[TB] %s ok %b", name, got);
        end
    endtask

    task automatic step(input logic [1:0] p);
        @(negedge clk);
        pulse_in = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk("reset_value", 12'b00_00_00_11_00_00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single ch0 pulse: on 1-4, gap 5-6, idle from 7; ch1 untouched.
        build(8, 64'h1, 64'h0, rm(1, 4), 64'h0, rm(1, 6), 64'h0, 64'h0);
        run("single");

`ifdef LED_STRETCH_QUEUE_EN
        // ch0 pulses at 0,2,3 queue up; ch1 independent single pulse at edge 1.
        build(20, 64'b1101, 64'b10, rm(1, 4) | rm(7, 10) | rm(13, 16), rm(2, 5),
              rm(1, 18), rm(2, 7), 64'h0);
        run("queued3");

        // Six pulses: counter saturates at 3, pulses at 4 and 5 are lost.
        build(26, rm(0, 5), 64'h0, rm(1, 4) | rm(7, 10) | rm(13, 16) | rm(19, 22), 64'h0,
              rm(1, 24), 64'h0, rm(5, 6));
        run("saturate");

        // Pulse in the final gap cycle with one pending: pending stays 1, no extra gap.
        build(20, 64'b1000101, 64'h0, rm(1, 4) | rm(7, 10) | rm(13, 16), 64'h0,
              rm(1, 18), 64'h0, 64'h0);
        run("gap_last");
`else
        // Pulse during ON is dropped and flagged the following cycle.
        build(8, 64'b101, 64'h0, rm(1, 4), 64'h0, rm(1, 6), 64'h0, 64'h8);
        run("drop_on");

        // Pulse in non-final gap cycle dropped; one in the final gap cycle accepted.
        build(14, 64'b1100001, 64'h0, rm(1, 4) | rm(7, 10), 64'h0, rm(1, 12), 64'h0,
              64'h40);
        run("gap_accept");
`endif

        // Reset mid-ON with events outstanding; outputs must clear before any edge.
        step(2'b01);
        step(2'b01);
        step(2'b01);
        #2 rst = 1'b1;
        #1 chk("rst_async", 12'b00_00_00_11_00_00);
        step(2'b01);
        chk("rst_pulse_ignored", 12'b00_00_00_11_00_00);
        @(negedge clk);
        pulse_in = '0;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1 chk($sformatf("post_rst_c%0d", c), 12'b00_00_00_11_00_00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
